// File: rtl/sdhci_cmd_pkg.sv
// Shared types for the SD command-line arbiter.
//  cmd_req_t   : command descriptor offered by each source and presented to the PHY
//  rsp_type_e  : expected response format of a command
//  ErrW/ERR_*  : per-source error flag vector and its bit positions
//  arb_state_e : arbiter FSM states
package sdhci_cmd_pkg;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_136  = 2'd1,
    RSP_48   = 2'd2,
    RSP_48B  = 2'd3
  } rsp_type_e;

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] arg;
    rsp_type_e   rsp_type;
    logic        chk_idx;
    logic        chk_crc;
  } cmd_req_t;

  localparam int ErrW         = 5;
  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_CRC      = 1;
  localparam int ERR_END_BIT  = 2;
  localparam int ERR_INDEX    = 3;
  localparam int ERR_NOT_EXEC = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    HALT     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sdhci_cmd_slot.sv
// One pending-command slot per command source.
//  clk, rst  : clock, synchronous active-high reset (clears the full bit only)
//  capture   : source handshake (valid & ready); loads new_cmd and marks the slot full
//  retire    : done pulse for this source; frees the slot at the end of that cycle
//  new_cmd   : descriptor offered by the source
//  full      : slot holds a command that has not yet retired
//  cmd       : stored descriptor, stable while full
module sdhci_cmd_slot
  import sdhci_cmd_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     capture,
  input  logic     retire,
  input  cmd_req_t new_cmd,
  output logic     full,
  output cmd_req_t cmd
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (retire) begin
      full <= 1'b0;
    end else if (capture) begin
      full <= 1'b1;
    end
  end

  // Descriptor is only meaningful while full, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      cmd <= new_cmd;
    end
  end

endmodule

// File: rtl/sdhci_cmd_arbiter.sv
// Fixed-priority CMD-line arbiter in front of the SD command PHY.
// Holds one command per source, issues one at a time, checks the response
// (index, CRC7, end bit, Ncr timeout) and reports per-source completion.
// A failed response flushes all other pending commands as not-executed and
// halts the arbiter until software acknowledges.
//  clk_i, rst_i      : clock, synchronous active-high reset
//  sd_clk_en_i       : one pulse per SD clock; paces the response timeout
//  src_valid_i/src_ready_o/src_cmd_i : per-source command offer handshake
//  src_done_o/src_err_o              : per-source retire pulse and error flags
//  cmd_valid_o/cmd_ready_i/cmd_o     : granted command towards the PHY
//  rsp_valid_i, rsp_index_i, rsp_crc_ok_i, rsp_end_ok_i : received response
//  busy_o, halted_o, err_ack_i       : status and halt acknowledge
module sdhci_cmd_arbiter
  import sdhci_cmd_pkg::*;
#(
  parameter int NumSrc      = 2,
  parameter int TimeoutClks = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           sd_clk_en_i,
  input  logic [NumSrc-1:0]              src_valid_i,
  output logic [NumSrc-1:0]              src_ready_o,
  input  cmd_req_t [NumSrc-1:0]          src_cmd_i,
  output logic [NumSrc-1:0]              src_done_o,
  output logic [NumSrc-1:0][ErrW-1:0]    src_err_o,
  output logic                           cmd_valid_o,
  input  logic                           cmd_ready_i,
  output cmd_req_t                       cmd_o,
  input  logic                           rsp_valid_i,
  input  logic [5:0]                     rsp_index_i,
  input  logic                           rsp_crc_ok_i,
  input  logic                           rsp_end_ok_i,
  output logic                           busy_o,
  output logic                           halted_o,
  input  logic                           err_ack_i
);

  localparam int CntW = $clog2(TimeoutClks + 1);
  localparam int IdxW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  arb_state_e          state;
  logic [IdxW-1:0]     grant_q;
  logic [CntW-1:0]     cnt;
  logic [CntW-1:0]     cnt_nxt;
  logic                timeout;
  logic [NumSrc-1:0]   slot_full;
  logic [NumSrc-1:0]   capture;
  logic [NumSrc-1:0]   pending;
  cmd_req_t            slot_cmd [NumSrc];
  cmd_req_t            cur_cmd;
  logic [ErrW-1:0]     fin_err;

  function automatic logic [IdxW-1:0] lowest_set(input logic [NumSrc-1:0] v);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (v[i]) idx = IdxW'(i);
    end
    return idx;
  endfunction

  function automatic logic [ErrW-1:0] rsp_check(input cmd_req_t c, input logic [5:0] idx,
                                                input logic crc_ok, input logic end_ok);
    logic [ErrW-1:0] e;
    e              = '0;
    e[ERR_INDEX]   = c.chk_idx & (idx != c.index);
    e[ERR_END_BIT] = ~end_ok;
    e[ERR_CRC]     = c.chk_crc & ~crc_ok;
    return e;
  endfunction

  // Ready is held low during reset so no command is captured while clearing.
  assign src_ready_o = ~slot_full & {NumSrc{~halted_o & ~rst_i}};
  assign capture     = src_valid_i & src_ready_o;
  // A slot in its done cycle is still full but must not be granted again.
  assign pending     = slot_full & ~src_done_o;

  for (genvar s = 0; s < NumSrc; s++) begin : g_slot
    sdhci_cmd_slot u_slot (
      .clk     (clk_i),
      .rst     (rst_i),
      .capture (capture[s]),
      .retire  (src_done_o[s]),
      .new_cmd (src_cmd_i[s]),
      .full    (slot_full[s]),
      .cmd     (slot_cmd[s])
    );
  end

  assign cur_cmd = slot_cmd[grant_q];
  assign cmd_o   = cmd_valid_o ? cur_cmd : cmd_req_t'('0);
  assign cnt_nxt = cnt + CntW'(sd_clk_en_i);
  assign timeout = (cnt_nxt == CntW'(TimeoutClks));

  // A response in the timeout cycle takes precedence over the timeout.
  always_comb begin
    fin_err = '0;
    if (rsp_valid_i) begin
      fin_err = rsp_check(cur_cmd, rsp_index_i, rsp_crc_ok_i, rsp_end_ok_i);
    end else if (timeout) begin
      fin_err[ERR_TIMEOUT] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      grant_q     <= '0;
      cnt         <= '0;
      cmd_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      halted_o    <= 1'b0;
      src_done_o  <= '0;
      src_err_o   <= '0;
    end else begin
      src_done_o <= '0;
      src_err_o  <= '0;
      case (state)
        IDLE: begin
          if (|pending) begin
            grant_q     <= lowest_set(pending);
            state       <= ISSUE;
            cmd_valid_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        ISSUE: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            if (cur_cmd.rsp_type == RSP_NONE) begin
              src_done_o[grant_q] <= 1'b1;
              state               <= IDLE;
              busy_o              <= 1'b0;
            end else begin
              cnt   <= '0;
              state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          cnt <= cnt_nxt;
          if (rsp_valid_i || timeout) begin
            src_done_o[grant_q] <= 1'b1;
            src_err_o[grant_q]  <= fin_err;
            if (fin_err == '0) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              state    <= HALT;
              halted_o <= 1'b1;
              for (int s = 0; s < NumSrc; s++) begin
                if (slot_full[s] && (IdxW'(s) != grant_q)) begin
                  src_done_o[s]               <= 1'b1;
                  src_err_o[s]                <= '0;
                  src_err_o[s][ERR_NOT_EXEC]  <= 1'b1;
                end
              end
            end
          end
        end
        HALT: begin
          if (err_ack_i) begin
            state    <= IDLE;
            halted_o <= 1'b0;
            busy_o   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdhci_cmd_arbiter.sv
// Scoreboard bench for sdhci_cmd_arbiter (NumSrc=2, TimeoutClks=64).
// Stimulus pushes expected PHY commands and per-source completions into
// queues; a negedge monitor pops and compares whenever the DUT issues a
// command or pulses src_done_o.
module tb_sdhci_cmd_arbiter;
  import sdhci_cmd_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sd_clk_en = 1'b0;
  logic [1:0]           src_valid;
  logic [1:0]           src_ready;
  cmd_req_t [1:0]       src_cmd;
  logic [1:0]           src_done;
  logic [1:0][ErrW-1:0] src_err;
  logic                 cmd_valid;
  logic                 cmd_ready;
  cmd_req_t             cmd;
  logic                 rsp_valid;
  logic [5:0]           rsp_index;
  logic                 rsp_crc_ok;
  logic                 rsp_end_ok;
  logic                 busy;
  logic                 halted;
  logic                 err_ack;

  sdhci_cmd_arbiter #(.NumSrc(2), .TimeoutClks(64)) dut (
    .clk_i(clk), .rst_i(rst), .sd_clk_en_i(sd_clk_en),
    .src_valid_i(src_valid), .src_ready_o(src_ready), .src_cmd_i(src_cmd),
    .src_done_o(src_done), .src_err_o(src_err),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_o(cmd),
    .rsp_valid_i(rsp_valid), .rsp_index_i(rsp_index),
    .rsp_crc_ok_i(rsp_crc_ok), .rsp_end_ok_i(rsp_end_ok),
    .busy_o(busy), .halted_o(halted), .err_ack_i(err_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             src;
    logic [ErrW-1:0] err;
  } done_t;

  done_t      exp_done_q[$];
  logic [5:0] exp_cmd_q[$];
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;
  int         en_cnt = 0;

  // SD clock enable: one pulse every 4th system clock, changed on negedge.
  always @(negedge clk) begin
    en_cnt++;
    sd_clk_en = ((en_cnt % 4) == 0);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic wait_expired(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired", name);
  endtask

  // Monitor: compares every command handshake and every done pulse.
  always @(negedge clk) begin
    done_t e;
    if (mon_en) begin
      for (int s = 0; s < 2; s++) begin
        if (src_done[s]) begin
          if (exp_done_q.size() == 0) begin
            check("unexpected_done_src", 64'(s), 64'hFF);
          end else begin
            e = exp_done_q.pop_front();
            check("done_src", 64'(s), 64'(e.src));
            check("done_err", 64'(src_err[s]), 64'(e.err));
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          check("unexpected_cmd_index", 64'(cmd.index), 64'hFF);
        end else begin
          check("cmd_index", 64'(cmd.index), 64'(exp_cmd_q.pop_front()));
        end
      end
    end
  end

  function automatic cmd_req_t mk(input logic [5:0] idx, input rsp_type_e rt);
    cmd_req_t c;
    c.index    = idx;
    c.arg      = 32'h0000_1000 + 32'(idx);
    c.rsp_type = rt;
    c.chk_idx  = 1'b1;
    c.chk_crc  = 1'b1;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] mask, input cmd_req_t c0, input cmd_req_t c1);
    logic [1:0] left;
    logic [1:0] hs;
    int n;
    left = mask;
    src_cmd[0] = c0;
    src_cmd[1] = c1;
    n = 0;
    while (left != 2'b00 && n < 50) begin
      src_valid = left;
      hs = left & src_ready;
      tick();
      left = left & ~hs;
      n++;
    end
    src_valid = 2'b00;
    if (left != 2'b00) wait_expired("offer");
  endtask

  task automatic wait_rsp_state();
    int n;
    n = 0;
    while (!(busy && !cmd_valid && !halted) && n < 50) begin
      tick();
      n++;
    end
    if (!(busy && !cmd_valid && !halted)) wait_expired("wait_rsp_state");
  endtask

  task automatic respond(input logic [5:0] idx, input logic crc_ok, input logic end_ok);
    wait_rsp_state();
    rsp_valid  = 1'b1;
    rsp_index  = idx;
    rsp_crc_ok = crc_ok;
    rsp_end_ok = end_ok;
    tick();
    rsp_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (busy) wait_expired("wait_idle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    rst = 1'b1;
    src_valid = 2'b00;
    src_cmd[0] = mk(6'd0, RSP_NONE);
    src_cmd[1] = mk(6'd0, RSP_NONE);
    cmd_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_index = 6'd0;
    rsp_crc_ok = 1'b1;
    rsp_end_ok = 1'b1;
    err_ack = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd", 64'(cmd), 64'd0);
    check("rst_done", 64'(src_done), 64'd0);
    check("rst_err", 64'(src_err), 64'd0);
    check("rst_ready", 64'(src_ready), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();
    check("post_rst_ready", 64'(src_ready), 64'h3);

    // 1: single RSP_NONE command from source 1, with issue latency
    exp_cmd_q.push_back(6'd0);
    exp_done_q.push_back('{src: 1, err: 5'b00000});
    offer(2'b10, mk(6'd0, RSP_NONE), mk(6'd0, RSP_NONE));
    check("t1_lat_idle_cycle", 64'(cmd_valid), 64'd0);
    tick();
    check("t1_lat_issue_cycle", 64'(cmd_valid), 64'd1);
    tick();
    check("t1_done", 64'(src_done), 64'h2);
    check("t1_busy_back", 64'(busy), 64'd0);
    check("t1_ready_during_done", 64'(src_ready), 64'h1);
    tick();
    check("t1_ready_after", 64'(src_ready), 64'h3);

    // 2: simultaneous offers, source 0 wins, both succeed in order
    exp_cmd_q.push_back(6'd12);
    exp_cmd_q.push_back(6'd0);
    exp_done_q.push_back('{src: 0, err: 5'b00000});
    exp_done_q.push_back('{src: 1, err: 5'b00000});
    offer(2'b11, mk(6'd12, RSP_48), mk(6'd0, RSP_48));
    respond(6'd12, 1'b1, 1'b1);
    respond(6'd0, 1'b1, 1'b1);
    wait_idle();
    tick();

    // 3: first response fails index and CRC -> flush and halt
    exp_cmd_q.push_back(6'd12);
    exp_done_q.push_back('{src: 0, err: 5'b01010});
    exp_done_q.push_back('{src: 1, err: 5'b10000});
    offer(2'b11, mk(6'd12, RSP_48), mk(6'd0, RSP_48));
    respond(6'h3F, 1'b0, 1'b1);
    check("t3_done_both", 64'(src_done), 64'h3);
    check("t3_halted", 64'(halted), 64'd1);
    check("t3_ready_halted", 64'(src_ready), 64'h0);
    repeat (5) tick();
    check("t3_no_issue", 64'(cmd_valid), 64'd0);
    check("t3_still_halted", 64'(halted), 64'd1);
    err_ack = 1'b1;
    tick();
    err_ack = 1'b0;
    check("t3_ack_halted", 64'(halted), 64'd0);
    check("t3_ack_busy", 64'(busy), 64'd0);
    check("t3_ack_ready", 64'(src_ready), 64'h3);

    // 4: no response -> timeout after 64 SD clock pulses
    exp_cmd_q.push_back(6'd12);
    exp_done_q.push_back('{src: 0, err: 5'b00001});
    offer(2'b01, mk(6'd12, RSP_48), mk(6'd0, RSP_48));
    wait_rsp_state();
    n = 0;
    k = 0;
    while (!src_done[0] && k < 1000) begin
      n += int'(sd_clk_en);
      tick();
      k++;
    end
    if (!src_done[0]) wait_expired("t4_timeout_done");
    check("t4_pulse_count", 64'(n), 64'd64);
    check("t4_halted", 64'(halted), 64'd1);
    err_ack = 1'b1;
    tick();
    err_ack = 1'b0;
    tick();

    // 5: source 0 arrives while source 1 waits for its response
    exp_cmd_q.push_back(6'd8);
    exp_cmd_q.push_back(6'd12);
    exp_done_q.push_back('{src: 1, err: 5'b00000});
    exp_done_q.push_back('{src: 0, err: 5'b00000});
    offer(2'b10, mk(6'd12, RSP_48), mk(6'd8, RSP_48));
    wait_rsp_state();
    offer(2'b01, mk(6'd12, RSP_48), mk(6'd8, RSP_48));
    tick();
    check("t5_no_preempt", 64'(cmd_valid), 64'd0);
    respond(6'd8, 1'b1, 1'b1);
    check("t5_src1_done", 64'(src_done), 64'h2);
    check("t5_not_yet_issued", 64'(cmd_valid), 64'd0);
    tick();
    check("t5_issue_next_cycle", 64'(cmd_valid), 64'd1);
    respond(6'd12, 1'b1, 1'b1);
    wait_idle();
    tick();

    // 6: reset while waiting for a response
    exp_cmd_q.push_back(6'd17);
    offer(2'b10, mk(6'd0, RSP_48), mk(6'd17, RSP_48));
    wait_rsp_state();
    rst = 1'b1;
    tick();
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_cmd_valid", 64'(cmd_valid), 64'd0);
    check("t6_done", 64'(src_done), 64'd0);
    check("t6_ready_in_rst", 64'(src_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("t6_ready_after", 64'(src_ready), 64'h3);
    rsp_valid = 1'b1;
    rsp_index = 6'd17;
    tick();
    rsp_valid = 1'b0;
    tick();
    check("t6_stray_rsp_done", 64'(src_done), 64'd0);
    check("t6_stray_rsp_busy", 64'(busy), 64'd0);
    repeat (3) tick();

    check("end_cmd_queue_empty", 64'(exp_cmd_q.size()), 64'd0);
    check("end_done_queue_empty", 64'(exp_done_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
